// File: rtl/rom_read_arbiter.sv
// Round-robin per-beat arbiter sharing one ROM read port between single reads (A) and bursts (B).
// Address-to-data latency is one cycle; neither side can stall returned data, and A pauses B at most every other beat.
module rom_read_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   input  logic                  b_req,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [LEN_WIDTH-1:0]  b_len,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   output logic                  b_done,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]           rom_data
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [LEN_WIDTH:0]    cnt, cnt_nxt;
   logic [LEN_WIDTH-1:0]  len, len_nxt;
   logic                  last, last_nxt;
   logic                  b_beat, b_final;
   logic [ADDR_WIDTH-1:0] cnt_ext;

   // cnt is one bit wider than len so an all-ones b_len never overflows
   assign cnt_ext = ADDR_WIDTH'(cnt);
   assign busy    = (state == BURST);

   always_comb begin
      state_nxt = state;
      base_nxt  = base;
      cnt_nxt   = cnt;
      len_nxt   = len;
      last_nxt  = last;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      b_beat    = 1'b0;
      b_final   = 1'b0;
      rom_addr  = '0;
      case (state)
         IDLE: begin
            if (a_req && (!b_req || last)) begin
               a_gnt    = 1'b1;
               rom_addr = a_addr;
               last_nxt = 1'b0;
            end else if (b_req) begin
               b_gnt    = 1'b1;
               b_beat   = 1'b1;
               rom_addr = b_addr;
               base_nxt = b_addr;
               len_nxt  = b_len;
               cnt_nxt  = {{LEN_WIDTH{1'b0}}, 1'b1};
               last_nxt = 1'b1;
               if (b_len == '0) b_final = 1'b1;
               else             state_nxt = BURST;
            end
         end
         BURST: begin
            // an A beat pauses the burst without advancing cnt
            if (a_req && last) begin
               a_gnt    = 1'b1;
               rom_addr = a_addr;
               last_nxt = 1'b0;
            end else begin
               b_beat   = 1'b1;
               rom_addr = base + cnt_ext;
               cnt_nxt  = cnt + 1'b1;
               last_nxt = 1'b1;
               if (cnt == {1'b0, len}) begin
                  b_final   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
         cnt   <= '0;
         len   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         base  <= base_nxt;
         cnt   <= cnt_nxt;
         len   <= len_nxt;
         last  <= last_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
         b_done   <= 1'b0;
      end else begin
         a_rvalid <= a_gnt;
         b_rvalid <= b_beat;
         b_done   <= b_final;
         if (a_gnt)  a_rdata <= rom_data;
         if (b_beat) b_rdata <= rom_data;
      end
   end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: per-scenario tasks push expected read data; a monitor pops and checks it.
module tb_rom_read_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0;
   logic [11:0] a_addr = '0;
   logic        a_gnt, a_rvalid;
   logic [31:0] a_rdata;
   logic        b_req = 1'b0;
   logic [11:0] b_addr = '0;
   logic [7:0]  b_len = '0;
   logic        b_gnt, b_rvalid, b_done, busy;
   logic [31:0] b_rdata;
   logic [11:0] rom_addr;
   logic [31:0] rom_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      logic        done;
      logic [31:0] data;
   } exp_t;

   exp_t a_q[$];
   exp_t b_q[$];
   exp_t e;

   function automatic logic [31:0] rom_fn(input logic [11:0] a);
      if (a == 12'h010) return 32'hDEADBEEF;
      return {a, 8'h3C, a};
   endfunction

   assign rom_data = rom_fn(rom_addr);

   rom_read_arbiter dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_len(b_len), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .b_rdata(b_rdata), .b_done(b_done), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every returned word must match the front entry, arrive in its due cycle, and carry the right b_done.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_rvalid) begin
            checks++;
            if (a_q.size() == 0) begin
               errors++;
               $display("FAIL a_unexpected_rvalid got data=%h cyc=%0d, required no valid", a_rdata, cyc);
            end else begin
               e = a_q.pop_front();
               if (a_rdata !== e.data || cyc != e.due) begin
                  errors++;
                  $display("FAIL a_rdata got=%h@%0d required=%h@%0d", a_rdata, cyc, e.data, e.due);
               end
            end
         end else if (a_q.size() > 0 && a_q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL a_missing_rvalid got none at cyc=%0d required data=%h", cyc, a_q[0].data);
            void'(a_q.pop_front());
         end
         if (b_rvalid) begin
            checks++;
            if (b_q.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected_rvalid got data=%h cyc=%0d, required no valid", b_rdata, cyc);
            end else begin
               e = b_q.pop_front();
               if (b_rdata !== e.data || b_done !== e.done || cyc != e.due) begin
                  errors++;
                  $display("FAIL b_rdata got=%h done=%b @%0d required=%h done=%b @%0d",
                           b_rdata, b_done, cyc, e.data, e.done, e.due);
               end
            end
         end else begin
            if (b_q.size() > 0 && b_q[0].due <= cyc) begin
               checks++; errors++;
               $display("FAIL b_missing_rvalid got none at cyc=%0d required data=%h", cyc, b_q[0].data);
               void'(b_q.pop_front());
            end
            if (b_done) begin
               checks++; errors++;
               $display("FAIL b_done_without_rvalid got=1 required=0");
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid, b_done, busy, a_gnt, b_gnt} !== 6'b0 || rom_addr !== 12'h000) begin
         errors++;
         $display("FAIL reset_ctrl got av=%b bv=%b dn=%b busy=%b ag=%b bg=%b addr=%h required all 0",
                  a_rvalid, b_rvalid, b_done, busy, a_gnt, b_gnt, rom_addr);
      end
      checks++;
      if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got a=%h b=%h required 0", a_rdata, b_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_tie();
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 12'h030; b_req = 1'b1; b_addr = 12'h200; b_len = 8'd0;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || rom_addr !== 12'h030) begin
         errors++;
         $display("FAIL tie_first got ag=%b bg=%b addr=%h required ag=1 bg=0 addr=030", a_gnt, b_gnt, rom_addr);
      end
      a_q.push_back('{cyc + 1, 1'b0, rom_fn(12'h030)});
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b1 || rom_addr !== 12'h200) begin
         errors++;
         $display("FAIL tie_second got ag=%b bg=%b addr=%h required ag=0 bg=1 addr=200", a_gnt, b_gnt, rom_addr);
      end
      b_q.push_back('{cyc + 1, 1'b1, rom_fn(12'h200)});
      @(posedge clk); #1;
      b_req = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || b_gnt !== 1'b0) begin
         errors++;
         $display("FAIL tie_len0_idle got busy=%b bg=%b required 0 0", busy, b_gnt);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 12'h010;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || rom_addr !== 12'h010) begin
         errors++;
         $display("FAIL single_gnt got ag=%b bg=%b addr=%h required 1 0 010", a_gnt, b_gnt, rom_addr);
      end
      a_q.push_back('{cyc + 1, 1'b0, 32'hDEADBEEF});
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b0 || rom_addr !== 12'h000) begin
         errors++;
         $display("FAIL single_idle got ag=%b addr=%h required 0 000", a_gnt, rom_addr);
      end
      @(negedge clk);
      checks++;
      if (a_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse got a_rvalid=%b required 0", a_rvalid);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         a_req = 1'b1; a_addr = 12'h050 + 12'(k);
         @(negedge clk);
         checks++;
         if (a_gnt !== 1'b1 || rom_addr !== 12'h050 + 12'(k)) begin
            errors++;
            $display("FAIL b2b_gnt%0d got ag=%b addr=%h required 1 %h", k, a_gnt, rom_addr, 12'h050 + 12'(k));
         end
         a_q.push_back('{cyc + 1, 1'b0, rom_fn(12'h050 + 12'(k))});
      end
      @(posedge clk); #1;
      a_req = 1'b0;
   endtask

   task automatic test_burst(input logic [11:0] base, input logic [7:0] len, input string name);
      logic [11:0] ea;
      for (int i = 0; i <= int'(len); i++) begin
         @(posedge clk); #1;
         b_req = (i == 0); b_addr = base; b_len = len;
         @(negedge clk);
         ea = base + 12'(i);
         checks++;
         if (b_gnt !== (i == 0) || a_gnt !== 1'b0 || rom_addr !== ea || busy !== (i != 0)) begin
            errors++;
            $display("FAIL %s_beat%0d got bg=%b ag=%b addr=%h busy=%b required bg=%b ag=0 addr=%h busy=%b",
                     name, i, b_gnt, a_gnt, rom_addr, busy, i == 0, ea, i != 0);
         end
         b_q.push_back('{cyc + 1, i == int'(len), rom_fn(ea)});
      end
      @(posedge clk); #1;
      b_req = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || b_gnt !== 1'b0) begin
         errors++;
         $display("FAIL %s_end got busy=%b bg=%b required 0 0", name, busy, b_gnt);
      end
   endtask

   task automatic test_contention();
      logic [11:0] ea;
      @(posedge clk); #1;
      b_req = 1'b1; b_addr = 12'h100; b_len = 8'd3; a_req = 1'b0;
      @(negedge clk);
      checks++;
      if (b_gnt !== 1'b1 || rom_addr !== 12'h100) begin
         errors++;
         $display("FAIL cont_start got bg=%b addr=%h required 1 100", b_gnt, rom_addr);
      end
      b_q.push_back('{cyc + 1, 1'b0, rom_fn(12'h100)});
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         b_req = 1'b0; a_req = 1'b1; a_addr = 12'h040 + 12'(k);
         @(negedge clk);
         ea = (k % 2 == 1) ? 12'h040 + 12'(k) : 12'h100 + 12'(k / 2);
         checks++;
         if (a_gnt !== (k % 2 == 1) || b_gnt !== 1'b0 || rom_addr !== ea || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_cycle%0d got ag=%b bg=%b addr=%h busy=%b required ag=%b bg=0 addr=%h busy=1",
                     k, a_gnt, b_gnt, rom_addr, busy, k % 2 == 1, ea);
         end
         if (k % 2 == 1) a_q.push_back('{cyc + 1, 1'b0, rom_fn(ea)});
         else            b_q.push_back('{cyc + 1, k == 6, rom_fn(ea)});
      end
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
         errors++;
         $display("FAIL cont_end got busy=%b ag=%b bg=%b required 0 0 0", busy, a_gnt, b_gnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         b_req = (i == 0); b_addr = 12'h300; b_len = 8'd7;
         @(negedge clk);
         checks++;
         if (rom_addr !== 12'h300 + 12'(i)) begin
            errors++;
            $display("FAIL rmid_beat%0d got addr=%h required %h", i, rom_addr, 12'h300 + 12'(i));
         end
         if (i < 2) b_q.push_back('{cyc + 1, 1'b0, rom_fn(12'h300 + 12'(i))});
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (b_rvalid !== 1'b0 || busy !== 1'b0 || b_done !== 1'b0) begin
         errors++;
         $display("FAIL rmid_immediate got bv=%b busy=%b done=%b required 0 0 0", b_rvalid, busy, b_done);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (b_rvalid !== 1'b0 || b_done !== 1'b0 || b_q.size() != 0) begin
         errors++;
         $display("FAIL rmid_held got bv=%b done=%b pending=%0d required 0 0 0", b_rvalid, b_done, b_q.size());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      test_single();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_tie();
      test_single();
      test_back_to_back();
      test_burst(12'h100, 8'd3, "burst");
      test_contention();
      test_burst(12'hFFE, 8'd3, "wrap");
      test_reset_mid_burst();
      repeat (3) @(negedge clk);
      checks++;
      if (a_q.size() != 0 || b_q.size() != 0) begin
         errors++;
         $display("FAIL drain got a_pending=%0d b_pending=%0d required 0 0", a_q.size(), b_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
